qdr_arbiter: RTL and testbench
==============================

QDR_ARBITER -- requirements
Module: qdr_arbiter

Interface
REQ-001 The block SHALL have parameter RD_TIMEOUT, default 63, giving the number of RD_WAIT cycles before an incomplete read is abandoned (range 2..255).
REQ-002 The block SHALL have port qdr_clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port qdr_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port phy_rdy, input, 1 bit: QDR PHY calibrated and ready.
REQ-005 The block SHALL have, per requester i in {0,1}, port req_i, input, 1 bit: command request, held until ack_i.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-007 The block SHALL have port addr_i, input, 32 bits: burst address.
REQ-008 The block SHALL have port wr_data_i, input, 144 bits: write burst, with [143:72] as beat 0 and [71:0] as beat 1.
REQ-009 The block SHALL have port ack_i, output, 1 bit: one-cycle pulse, command accepted.
REQ-010 The block SHALL have port rd_data_i, output, 72 bits: read beat.
REQ-011 The block SHALL have port rd_dvld_i, output, 1 bit: rd_data_i valid.
REQ-012 The block SHALL have port qdr_addr, output, 32 bits: QDR user address.
REQ-013 The block SHALL have port qdr_wr_en, output, 1 bit: write burst start.
REQ-014 The block SHALL have port qdr_wr_data, output, 72 bits: write beat.
REQ-015 The block SHALL have port qdr_rd_en, output, 1 bit: read burst start.
REQ-016 The block SHALL have port qdr_rd_data, input, 72 bits: returned read beat.
REQ-017 The block SHALL have port qdr_rd_dvld, input, 1 bit: qdr_rd_data valid.
REQ-018 The block SHALL have port rd_timeout, output, 1 bit: one-cycle pulse, read abandoned.

Function
REQ-019 The FSM SHALL have states IDLE, WR0, WR1, RD_ISSUE and RD_WAIT.
REQ-020 In IDLE with phy_rdy=1 and at least one req_i=1 at a clock edge, the block SHALL latch the owner, we, addr and wr_data, pulse ack_owner in the next cycle, and enter WR0 (we=1) or RD_ISSUE (we=0).
REQ-021 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; the last-granted pointer resets to 1 so that requester 0 wins first.
REQ-022 In IDLE with phy_rdy=0, the block SHALL issue no grant; a transaction already past IDLE SHALL complete regardless of phy_rdy.
REQ-023 In WR0, qdr_wr_en SHALL be 1 and qdr_wr_data SHALL be latched beat 0; the next state SHALL be WR1.
REQ-024 In WR1, qdr_wr_en SHALL be 0 and qdr_wr_data SHALL be latched beat 1; the next state SHALL be IDLE.
REQ-025 Outside WR0, qdr_wr_data SHALL carry latched beat 1.
REQ-026 In RD_ISSUE, qdr_rd_en SHALL be 1 for exactly that cycle; the next state SHALL be RD_WAIT with the beat and timeout counters cleared.
REQ-027 In RD_WAIT, each qdr_rd_dvld=1 SHALL assert rd_dvld_owner combinationally in the same cycle with rd_data_owner=qdr_rd_data, and SHALL increment the beat counter.
REQ-028 After the second beat, the block SHALL return to IDLE on the next edge.
REQ-029 rd_data_0 and rd_data_1 SHALL both always carry qdr_rd_data; rd_dvld SHALL be asserted only to the owner, and only in RD_WAIT.
REQ-030 qdr_rd_dvld outside RD_WAIT SHALL be ignored and not forwarded.
REQ-031 If RD_TIMEOUT cycles elapse in RD_WAIT without two beats, the block SHALL go to IDLE and pulse rd_timeout for one cycle.
REQ-032 qdr_addr SHALL be registered, change only on grant, and hold its value in all other states.
REQ-033 Latency SHALL be: req sampled at edge n -> ack and qdr_wr_en/qdr_rd_en high in cycle n+1; a write returns to IDLE at n+3; at least one IDLE cycle separates transactions.
REQ-034 A requester dropping req before ack SHALL be legal; the command is considered withdrawn unless already latched.

Reset
REQ-035 Assertion of qdr_rst_n=0 SHALL immediately force state IDLE and clear ack_i, qdr_wr_en, qdr_rd_en, rd_timeout, qdr_addr, the latched data, and both counters, regardless of the clock.
REQ-036 Reset mid-transaction SHALL abort the transaction without pulsing ack or rd_timeout; read beats arriving after reset SHALL be dropped.
REQ-037 Release of reset SHALL be synchronised by the integrator; the block SHALL make its first grant no earlier than the second edge after release.

Verification
REQ-038 Write: req_0=1, we_0=1, addr_0=0x100, wr_data_0={72'hA..,72'h5..} -> ack_0 at n+1, qdr_wr_en one cycle, qdr_wr_data=A.. then 5.., qdr_addr=0x100.
REQ-039 Read: req_1 read at 0x200, two qdr_rd_dvld beats 0x11/0x22 -> qdr_rd_en one cycle, rd_dvld_1 twice with 0x11 and 0x22, rd_dvld_0 stays 0.
REQ-040 Contention: both requesters held high for four transactions -> grants alternate 0,1,0,1.
REQ-041 Timeout: read with RD_TIMEOUT=8 and no dvld -> rd_timeout pulse 8 cycles after RD_WAIT entry, then IDLE, then a new grant accepted.
REQ-042 phy_rdy=0 with req_0=1 -> no ack; raise phy_rdy -> ack_0 next cycle.
REQ-043 Async reset asserted in RD_WAIT -> outputs zero immediately, a late dvld is not forwarded.

Source files
------------

// File: rtl/qdr_arbiter.sv
// rtl/qdr_arbiter.sv - two-requester round-robin arbiter in front of a QDR PHY user port
// Writes go out as two beats; reads wait for two returned beats or abandon after RD_TIMEOUT cycles.
module qdr_arbiter #(
  parameter int RD_TIMEOUT = 63
) (
  input  logic          qdr_clk,
  input  logic          qdr_rst_n,
  input  logic          phy_rdy,
  input  logic          req_0,
  input  logic          we_0,
  input  logic [31:0]   addr_0,
  input  logic [143:0]  wr_data_0,
  output logic          ack_0,
  output logic [71:0]   rd_data_0,
  output logic          rd_dvld_0,
  input  logic          req_1,
  input  logic          we_1,
  input  logic [31:0]   addr_1,
  input  logic [143:0]  wr_data_1,
  output logic          ack_1,
  output logic [71:0]   rd_data_1,
  output logic          rd_dvld_1,
  output logic [31:0]   qdr_addr,
  output logic          qdr_wr_en,
  output logic [71:0]   qdr_wr_data,
  output logic          qdr_rd_en,
  input  logic [71:0]   qdr_rd_data,
  input  logic          qdr_rd_dvld,
  output logic          rd_timeout
);

  typedef enum logic [2:0] {IDLE, WR0, WR1, RD_ISSUE, RD_WAIT} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          armed_q, armed_d;
  logic [31:0]   addr_q, addr_d;
  logic [143:0]  wr_data_q, wr_data_d;
  logic [1:0]    ack_q, ack_d;
  logic          rd_timeout_q, rd_timeout_d;
  logic [1:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          sel;
  logic          sel_we;

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      ack_q        <= '0;
      rd_timeout_q <= 1'b0;
      beat_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      armed_q      <= armed_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      ack_q        <= ack_d;
      rd_timeout_q <= rd_timeout_d;
      beat_cnt_q   <= beat_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    armed_d      = 1'b1;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    ack_d        = 2'b00;
    rd_timeout_d = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    // With both requesting, the one not granted last wins
    sel          = (req_0 && req_1) ? ~last_q : req_1;
    sel_we       = sel ? we_1 : we_0;

    case (state_q)
      IDLE: begin
        // armed_q holds off the first grant until the second edge after reset release
        if (armed_q && phy_rdy && (req_0 || req_1)) begin
          owner_d   = sel;
          last_d    = sel;
          addr_d    = sel ? addr_1 : addr_0;
          wr_data_d = sel ? wr_data_1 : wr_data_0;
          ack_d     = sel ? 2'b10 : 2'b01;
          state_d   = sel_we ? WR0 : RD_ISSUE;
        end
      end
      WR0: state_d = WR1;
      WR1: state_d = IDLE;
      RD_ISSUE: begin
        beat_cnt_d = '0;
        tmo_cnt_d  = '0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (qdr_rd_dvld) beat_cnt_d = beat_cnt_q + 2'd1;
        if (qdr_rd_dvld && beat_cnt_q == 2'd1) begin
          state_d = IDLE;
        end else if (tmo_cnt_q == 8'(RD_TIMEOUT - 1)) begin
          state_d      = IDLE;
          rd_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_0       = ack_q[0];
  assign ack_1       = ack_q[1];
  assign qdr_addr    = addr_q;
  assign qdr_wr_en   = (state_q == WR0);
  assign qdr_rd_en   = (state_q == RD_ISSUE);
  assign qdr_wr_data = (state_q == WR0) ? wr_data_q[143:72] : wr_data_q[71:0];
  assign rd_data_0   = qdr_rd_data;
  assign rd_data_1   = qdr_rd_data;
  assign rd_dvld_0   = (state_q == RD_WAIT) && qdr_rd_dvld && !owner_q;
  assign rd_dvld_1   = (state_q == RD_WAIT) && qdr_rd_dvld && owner_q;
  assign rd_timeout  = rd_timeout_q;

endmodule

// File: tb/tb_qdr_arbiter.sv
// tb/tb_qdr_arbiter.sv - directed self-checking bench for qdr_arbiter
module tb_qdr_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          phy_rdy;
  logic          req_0, we_0, req_1, we_1;
  logic [31:0]   addr_0, addr_1;
  logic [143:0]  wr_data_0, wr_data_1;
  logic          ack_0, ack_1, rd_dvld_0, rd_dvld_1;
  logic [71:0]   rd_data_0, rd_data_1;
  logic [31:0]   qdr_addr;
  logic          qdr_wr_en, qdr_rd_en, rd_timeout;
  logic [71:0]   qdr_wr_data;
  logic [71:0]   qdr_rd_data;
  logic          qdr_rd_dvld;

  int total = 0;
  int bad   = 0;

  localparam logic [71:0] BEAT_A = 72'hAAAAAAAAAAAAAAAAAA;
  localparam logic [71:0] BEAT_5 = 72'h555555555555555555;

  always #5 clk = ~clk;

  qdr_arbiter #(.RD_TIMEOUT(8)) dut (
    .qdr_clk(clk), .qdr_rst_n(rst_n), .phy_rdy(phy_rdy),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wr_data_0(wr_data_0),
    .ack_0(ack_0), .rd_data_0(rd_data_0), .rd_dvld_0(rd_dvld_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wr_data_1(wr_data_1),
    .ack_1(ack_1), .rd_data_1(rd_data_1), .rd_dvld_1(rd_dvld_1),
    .qdr_addr(qdr_addr), .qdr_wr_en(qdr_wr_en), .qdr_wr_data(qdr_wr_data),
    .qdr_rd_en(qdr_rd_en), .qdr_rd_data(qdr_rd_data), .qdr_rd_dvld(qdr_rd_dvld),
    .rd_timeout(rd_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; phy_rdy = 1'b1;
    req_0 = 0; we_0 = 0; addr_0 = '0; wr_data_0 = '0;
    req_1 = 0; we_1 = 0; addr_1 = '0; wr_data_1 = '0;
    qdr_rd_data = '0; qdr_rd_dvld = 0;
    tick; tick;
    total++; if ({ack_0, ack_1, qdr_wr_en, qdr_rd_en, rd_timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {ack_0, ack_1, qdr_wr_en, qdr_rd_en, rd_timeout});
    end
    total++; if (qdr_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", qdr_addr); end
    total++; if (qdr_wr_data !== 72'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", qdr_wr_data); end
    rst_n = 1'b1;
    req_0 = 1; we_0 = 1; addr_0 = 32'h100; wr_data_0 = {BEAT_A, BEAT_5};
    tick;
    total++; if (ack_0 !== 1'b0 || qdr_wr_en !== 1'b0) begin
      bad++; $display("FAIL first_edge_no_grant got ack=%b wr_en=%b exp=0 0", ack_0, qdr_wr_en);
    end
  endtask

  task automatic test_write;
    tick;
    total++; if (ack_0 !== 1'b1 || ack_1 !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=01", ack_1, ack_0); end
    total++; if (qdr_wr_en !== 1'b1) begin bad++; $display("FAIL wr_en0 got=%b exp=1", qdr_wr_en); end
    total++; if (qdr_wr_data !== BEAT_A) begin bad++; $display("FAIL wr_beat0 got=%h exp=%h", qdr_wr_data, BEAT_A); end
    total++; if (qdr_addr !== 32'h100) begin bad++; $display("FAIL wr_addr got=%h exp=100", qdr_addr); end
    req_0 = 0;
    tick;
    total++; if (ack_0 !== 1'b0 || qdr_wr_en !== 1'b0) begin bad++; $display("FAIL wr1_ctrl got ack=%b wr_en=%b exp=0 0", ack_0, qdr_wr_en); end
    total++; if (qdr_wr_data !== BEAT_5) begin bad++; $display("FAIL wr_beat1 got=%h exp=%h", qdr_wr_data, BEAT_5); end
    tick;
    total++; if (qdr_wr_en !== 1'b0 || qdr_addr !== 32'h100 || qdr_wr_data !== BEAT_5) begin
      bad++; $display("FAIL wr_idle got wr_en=%b addr=%h data=%h exp=0 100 %h", qdr_wr_en, qdr_addr, qdr_wr_data, BEAT_5);
    end
  endtask

  task automatic test_read;
    req_1 = 1; we_1 = 0; addr_1 = 32'h200;
    tick;
    total++; if (ack_1 !== 1'b1 || ack_0 !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b%b exp=10", ack_1, ack_0); end
    total++; if (qdr_rd_en !== 1'b1 || qdr_addr !== 32'h200) begin
      bad++; $display("FAIL rd_issue got rd_en=%b addr=%h exp=1 200", qdr_rd_en, qdr_addr);
    end
    req_1 = 0;
    tick;
    total++; if (qdr_rd_en !== 1'b0 || ack_1 !== 1'b0) begin bad++; $display("FAIL rd_wait_ctrl got rd_en=%b ack=%b exp=0 0", qdr_rd_en, ack_1); end
    qdr_rd_data = 72'h11; qdr_rd_dvld = 1; #1;
    total++; if (rd_dvld_1 !== 1'b1 || rd_dvld_0 !== 1'b0 || rd_data_1 !== 72'h11 || rd_data_0 !== 72'h11) begin
      bad++; $display("FAIL rd_beat0 got dv1=%b dv0=%b d1=%h d0=%h exp=1 0 11 11", rd_dvld_1, rd_dvld_0, rd_data_1, rd_data_0);
    end
    tick;
    qdr_rd_data = 72'h22; #1;
    total++; if (rd_dvld_1 !== 1'b1 || rd_dvld_0 !== 1'b0 || rd_data_1 !== 72'h22) begin
      bad++; $display("FAIL rd_beat1 got dv1=%b dv0=%b d1=%h exp=1 0 22", rd_dvld_1, rd_dvld_0, rd_data_1);
    end
    tick;
    total++; if (rd_dvld_1 !== 1'b0 || rd_dvld_0 !== 1'b0) begin
      bad++; $display("FAIL rd_stray_dvld got dv1=%b dv0=%b exp=0 0", rd_dvld_1, rd_dvld_0);
    end
    qdr_rd_dvld = 0;
  endtask

  task automatic test_contention;
    logic [3:0] order;
    int         n;
    order = '0; n = 0;
    req_0 = 1; we_0 = 1; addr_0 = 32'h1000;
    req_1 = 1; we_1 = 1; addr_1 = 32'h2000;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick;
      total++; if (ack_0 && ack_1) begin bad++; $display("FAIL cont_double_ack got=11 exp=one-hot"); end
      if (ack_0 || ack_1) begin
        order[n] = ack_1;
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL cont_grant_count got=%0d exp=4", n); end
    total++; if (order !== 4'b1010) begin bad++; $display("FAIL cont_order got=%b exp=1010 (bit0 first)", order); end
    req_0 = 0; req_1 = 0;
    tick; tick;
  endtask

  task automatic test_timeout;
    req_0 = 1; we_0 = 0; addr_0 = 32'h300;
    tick;
    total++; if (ack_0 !== 1'b1 || qdr_rd_en !== 1'b1) begin bad++; $display("FAIL to_grant got ack=%b rd_en=%b exp=1 1", ack_0, qdr_rd_en); end
    req_0 = 0;
    tick;
    for (int i = 1; i < 8; i++) begin
      tick;
      total++; if (rd_timeout !== 1'b0) begin bad++; $display("FAIL to_early cycle=%0d got=%b exp=0", i, rd_timeout); end
    end
    tick;
    total++; if (rd_timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", rd_timeout); end
    req_1 = 1; we_1 = 1; addr_1 = 32'h400;
    tick;
    total++; if (rd_timeout !== 1'b0 || ack_1 !== 1'b1 || qdr_addr !== 32'h400 || qdr_wr_en !== 1'b1) begin
      bad++; $display("FAIL to_regrant got to=%b ack1=%b addr=%h wr_en=%b exp=0 1 400 1", rd_timeout, ack_1, qdr_addr, qdr_wr_en);
    end
    req_1 = 0;
    tick; tick;
  endtask

  task automatic test_phy_rdy;
    phy_rdy = 0; req_0 = 1; we_0 = 1; addr_0 = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (ack_0 !== 1'b0 || qdr_wr_en !== 1'b0) begin
        bad++; $display("FAIL phy_block cycle=%0d got ack=%b wr_en=%b exp=0 0", i, ack_0, qdr_wr_en);
      end
    end
    phy_rdy = 1;
    tick;
    total++; if (ack_0 !== 1'b1 || qdr_addr !== 32'h500) begin bad++; $display("FAIL phy_grant got ack=%b addr=%h exp=1 500", ack_0, qdr_addr); end
    req_0 = 0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    req_1 = 1; we_1 = 0; addr_1 = 32'h600;
    tick;
    total++; if (ack_1 !== 1'b1) begin bad++; $display("FAIL rm_ack got=%b exp=1", ack_1); end
    req_1 = 0;
    tick;
    qdr_rd_data = 72'h33; qdr_rd_dvld = 1; #1;
    total++; if (rd_dvld_1 !== 1'b1) begin bad++; $display("FAIL rm_beat got=%b exp=1", rd_dvld_1); end
    #1 rst_n = 0; #1;
    total++; if ({rd_dvld_0, rd_dvld_1, ack_0, ack_1, qdr_wr_en, qdr_rd_en, rd_timeout} !== 7'b0) begin
      bad++; $display("FAIL rm_async_ctrl got=%b exp=0000000", {rd_dvld_0, rd_dvld_1, ack_0, ack_1, qdr_wr_en, qdr_rd_en, rd_timeout});
    end
    total++; if (qdr_addr !== 32'h0 || qdr_wr_data !== 72'h0) begin
      bad++; $display("FAIL rm_async_data got addr=%h wdata=%h exp=0 0", qdr_addr, qdr_wr_data);
    end
    tick;
    rst_n = 1;
    tick;
    total++; if (rd_dvld_1 !== 1'b0 || rd_timeout !== 1'b0 || ack_1 !== 1'b0) begin
      bad++; $display("FAIL rm_late_dvld got dv1=%b to=%b ack1=%b exp=0 0 0", rd_dvld_1, rd_timeout, ack_1);
    end
    qdr_rd_dvld = 0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_contention;
    test_timeout;
    test_phy_rdy;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
